mem_access_ctrl: RTL and testbench

Sequencer for the MEM stage of the RISC-V-lite pipeline: it accepts the load/store in MEM, runs a request/grant/response handshake with a variable-latency data memory, and aligns and extends load data. It drives the MEM/WB pipeline-register enable (`memRegEn`) and a stall to the upstream stages until the access completes. It also flags illegal accesses so the control unit can trap.

---
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer.
// Accepts the load/store present in MEM, runs a req/gnt/rvalid handshake
// with a variable-latency data memory, aligns and extends load data, and
// stalls the upstream pipeline until the access completes.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   op_valid, mem_rd, mem_wr  instruction in MEM and its access type
//   funct3, addr, wdata       access size/sign, byte address, store data
//   dmem_req/we/addr/wdata/be request side of the data-memory handshake
//   dmem_gnt, dmem_rvalid,    grant, read-data valid and read word
//   dmem_rdata
//   load_data, load_valid     aligned/extended load result, 1-cycle pulse
//   mem_reg_en, stall         MEM/WB enable and upstream freeze
//   access_err                illegal access (no request issued)
module mem_access_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic         mem_rd,
  input  logic         mem_wr,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  output logic [3:0]   dmem_be,
  input  logic         dmem_gnt,
  input  logic         dmem_rvalid,
  input  logic [N-1:0] dmem_rdata,
  output logic [N-1:0] load_data,
  output logic         load_valid,
  output logic         mem_reg_en,
  output logic         stall,
  output logic         access_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t       state, state_nxt;
  logic [2:0]   f3_q;
  logic [1:0]   off_q;
  logic         mem_op;
  logic         illegal;
  logic         start;
  logic [N-1:0] byte_sh;
  logic [N-1:0] half_sh;
  logic [N-1:0] ld_ext;

  assign mem_op = op_valid & (mem_rd | mem_wr);

  always_comb begin
    illegal = 1'b0;
    if (mem_rd & mem_wr) illegal = 1'b1;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
    if (mem_wr && (funct3 == 3'b100 || funct3 == 3'b101)) illegal = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0]) illegal = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) illegal = 1'b1;
  end

  assign start = (state == IDLE) & mem_op & ~illegal;

  // Lane select for loads uses the offset captured at issue, not the
  // live address, since the upstream stage may move on after DONE.
  always_comb begin
    byte_sh = dmem_rdata >> {off_q, 3'b000};
    half_sh = dmem_rdata >> {off_q[1], 4'b0000};
    case (f3_q)
      3'b000:  ld_ext = {{(N-8){byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  ld_ext = {{(N-8){1'b0}}, byte_sh[7:0]};
      3'b001:  ld_ext = {{(N-16){half_sh[15]}}, half_sh[15:0]};
      3'b101:  ld_ext = {{(N-16){1'b0}}, half_sh[15:0]};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ:  if (dmem_gnt) state_nxt = dmem_we ? DONE : WAIT;
      WAIT: if (dmem_rvalid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      load_data  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        dmem_we   <= mem_wr;
        dmem_addr <= {addr[N-1:2], 2'b00};
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        case (funct3[1:0])
          2'b00: begin
            dmem_be    <= 4'b0001 << addr[1:0];
            dmem_wdata <= {4{wdata[7:0]}};
          end
          2'b01: begin
            dmem_be    <= 4'b0011 << {addr[1], 1'b0};
            dmem_wdata <= {2{wdata[15:0]}};
          end
          default: begin
            dmem_be    <= 4'b1111;
            dmem_wdata <= wdata;
          end
        endcase
      end
      if (state == WAIT && dmem_rvalid) load_data <= ld_ext;
    end
  end

  assign dmem_req   = (state == REQ);
  assign load_valid = (state == DONE) & ~dmem_we;
  assign stall      = start | (state == REQ) | (state == WAIT);
  assign mem_reg_en = ~stall;
  assign access_err = (state == IDLE) & mem_op & illegal;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        load_valid, mem_reg_en, stall, access_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.N(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .load_valid(load_valid), .mem_reg_en(mem_reg_en),
    .stall(stall), .access_err(access_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdly;   // REQ cycles without grant
    int          rdly;   // cycles from grant to rvalid (>=1)
    logic        err;
    logic [31:0] exp_addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          nstall;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, gcyc, nst, nreq, nlv;
    logic bad;
    logic done;
    logic [31:0] ld;
    @(negedge clk);
    op_valid = 1'b1; mem_rd = v.rd; mem_wr = v.wr; funct3 = v.f3;
    addr = v.addr; wdata = v.wdata; dmem_rdata = v.rdata;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check($sformatf("v%0d access_err", idx), {31'b0, access_err}, {31'b0, v.err});
    if (v.err) begin
      check($sformatf("v%0d err stall/req/en", idx), {29'b0, stall, dmem_req, mem_reg_en}, 32'b001);
      @(negedge clk);
      check($sformatf("v%0d err next stall/req", idx), {30'b0, stall, dmem_req}, 32'b0);
      op_valid = 1'b0;
      return;
    end
    cyc = 0; gcyc = -100; nst = 0; nreq = 0; nlv = 0; bad = 1'b0; done = 1'b0; ld = '0;
    while (!done && cyc < 60) begin
      if (stall) nst++;
      if (mem_reg_en !== ~stall) bad = 1'b1;
      if (load_valid) begin nlv++; ld = load_data; end
      if (dmem_req) begin
        nreq++;
        if (dmem_addr !== v.exp_addr || dmem_be !== v.be ||
            dmem_we !== v.wr || dmem_wdata !== v.wd) bad = 1'b1;
      end
      if (!stall) begin
        done = 1'b1;
        op_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        check($sformatf("v%0d mem_reg_en in DONE", idx), {31'b0, mem_reg_en}, 32'd1);
      end else begin
        dmem_gnt = dmem_req && (nreq > v.gdly);
        if (dmem_gnt) gcyc = cyc;
        dmem_rvalid = !dmem_req && (cyc == gcyc + v.rdly);
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d completed", idx), {31'b0, done}, 32'd1);
    check($sformatf("v%0d stall cycles", idx), nst, v.nstall);
    check($sformatf("v%0d req cycles", idx), nreq, v.gdly + 1);
    check($sformatf("v%0d req fields stable", idx), {31'b0, bad}, 32'd0);
    check($sformatf("v%0d load_valid pulses", idx), nlv, v.rd ? 1 : 0);
    if (v.rd) check($sformatf("v%0d load_data", idx), ld, v.ld);
    check($sformatf("v%0d after DONE idle", idx), {30'b0, load_valid, stall}, 32'd0);
  endtask

  initial begin
    //           rd    wr    f3      addr          wdata         rdata       gd rd err  exp_addr     be       wd         st ld
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 1'b0, 32'h100, 4'b1111, 32'hDEADBEEF, 2, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 1, 1'b0, 32'h100, 4'b1000, 32'hA5A5A5A5, 2, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0,        0, 1, 1'b0, 32'h100, 4'b1100, 32'hBEEFBEEF, 2, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0,        32'h12F03456, 0, 1, 1'b0, 32'h100, 4'b0100, 32'h0, 3, 32'hFFFFFFF0};
    vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h12F03456, 0, 1, 1'b0, 32'h100, 4'b0100, 32'h0, 3, 32'h000000F0};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h12F03456, 0, 1, 1'b0, 32'h100, 4'b1100, 32'h0, 3, 32'h000012F0};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h12F08456, 0, 1, 1'b0, 32'h100, 4'b0011, 32'h0, 3, 32'hFFFF8456};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 3, 2, 1'b0, 32'h104, 4'b1111, 32'h0, 7, 32'hCAFEF00D};
    vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h12F03456, 0, 1, 1'b0, 32'h100, 4'b0010, 32'h0, 3, 32'h00000034};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,   4'b0000, 32'h0, 0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,   4'b0000, 32'h0, 0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,   4'b0000, 32'h0, 0, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,   4'b0000, 32'h0, 0, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,   4'b0000, 32'h0, 0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 3'b010, 32'h200, 32'h11223344, 32'h0,        2, 1, 1'b0, 32'h200, 4'b1111, 32'h11223344, 4, 32'h0};

    rst = 1'b1; op_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset req/we/be", {27'b0, dmem_req, dmem_we, dmem_be}, 32'h0);
    check("reset dmem_addr", dmem_addr, 32'h0);
    check("reset dmem_wdata", dmem_wdata, 32'h0);
    check("reset load_data", load_data, 32'h0);
    check("reset lv/stall/en/err", {28'b0, load_valid, stall, mem_reg_en, access_err}, 32'b0010);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(negedge clk);
    op_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010;
    addr = 32'h10; dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("rst-seq in REQ", {31'b0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("rst-seq in WAIT stall/req", {30'b0, stall, dmem_req}, 32'b10);
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1'b1;
    #1;
    check("rst-seq idle stall/req/lv", {29'b0, stall, dmem_req, load_valid}, 32'b0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("rst-seq late rvalid lv/req/stall", {29'b0, load_valid, dmem_req, stall}, 32'b0);
    check("rst-seq load_data", load_data, 32'h0);
    @(negedge clk);
    check("rst-seq still idle", {29'b0, load_valid, dmem_req, stall}, 32'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
